// File: rtl/exc_pkg.sv
// Shared encodings for the exception controller: FSM states, cause codes,
// handler vector selects and the EPC adjustment.
package exc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    ADDR = 2'b01,
    WAIT = 2'b10,
    LOAD = 2'b11
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'b00,
    CAUSE_OPCODE   = 2'b01,
    CAUSE_OVERFLOW = 2'b10,
    CAUSE_DIV0     = 2'b11
  } cause_t;

  localparam logic [2:0]  VEC_OPCODE   = 3'b010;  // handler byte at 253
  localparam logic [2:0]  VEC_OVERFLOW = 3'b011;  // handler byte at 254
  localparam logic [2:0]  VEC_DIV0     = 3'b100;  // handler byte at 255
  localparam logic [31:0] EPC_OFFSET   = 32'd4;

  function automatic logic [2:0] cause_to_vec(input cause_t c);
    unique case (c)
      CAUSE_OPCODE:   return VEC_OPCODE;
      CAUSE_OVERFLOW: return VEC_OVERFLOW;
      CAUSE_DIV0:     return VEC_DIV0;
      default:        return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/exc_priority_enc.sv
// Fixed-priority cause encoder: invalid opcode beats overflow beats div0.
module exc_priority_enc
  import exc_pkg::*;
(
  input  logic   exc_opcode,
  input  logic   exc_overflow,
  input  logic   exc_div0,
  output logic   valid,
  output cause_t cause
);

  always_comb begin
    valid = exc_opcode | exc_overflow | exc_div0;
    cause = CAUSE_NONE;
    if (exc_opcode)        cause = CAUSE_OPCODE;
    else if (exc_overflow) cause = CAUSE_OVERFLOW;
    else if (exc_div0)     cause = CAUSE_DIV0;
  end

endmodule

// File: rtl/exception_ctrl.sv
// Exception controller: latches cause and EPC, fetches the handler address
// byte from a fixed vector location and loads it into the PC.
module exception_ctrl
  import exc_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [2:0]  ctrl_iord_sel,
  input  logic        exc_opcode,
  input  logic        exc_overflow,
  input  logic        exc_div0,
  input  logic [31:0] pc_in,
  input  logic [31:0] mem_data_in,
  output logic [2:0]  iord_sel,
  output logic [31:0] epc_out,
  output logic        epc_write,
  output logic [31:0] pc_next,
  output logic        pc_load,
  output logic        exc_active,
  output logic [1:0]  exc_cause
);

  state_t     state;
  cause_t     cause_q;
  logic [2:0] vec_sel;
  logic       enc_valid;
  cause_t     enc_cause;
  logic       unused_mem_hi;

  assign unused_mem_hi = ^mem_data_in[31:8];
  assign exc_cause     = cause_q;

  exc_priority_enc u_enc (
    .exc_opcode   (exc_opcode),
    .exc_overflow (exc_overflow),
    .exc_div0     (exc_div0),
    .valid        (enc_valid),
    .cause        (enc_cause)
  );

  // Main control may only select PC (000) or ALUOut (001); vector codes are ours.
  always_comb begin
    iord_sel = 3'b000;
    unique case (state)
      IDLE:       iord_sel = (ctrl_iord_sel <= 3'b001) ? ctrl_iord_sel : 3'b000;
      ADDR, WAIT: iord_sel = vec_sel;
      LOAD:       iord_sel = 3'b000;
      default:    iord_sel = 3'b000;
    endcase
  end

  // The handler byte is captured straight into pc_next at the end of WAIT,
  // so pc_next already holds it for the whole LOAD cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state      <= IDLE;
      cause_q    <= CAUSE_NONE;
      vec_sel    <= '0;
      epc_out    <= '0;
      pc_next    <= '0;
      epc_write  <= 1'b0;
      pc_load    <= 1'b0;
      exc_active <= 1'b0;
    end else begin
      epc_write <= 1'b0;
      pc_load   <= 1'b0;
      unique case (state)
        IDLE: begin
          if (enc_valid) begin
            state      <= ADDR;
            cause_q    <= enc_cause;
            vec_sel    <= cause_to_vec(enc_cause);
            epc_out    <= pc_in - EPC_OFFSET;
            epc_write  <= 1'b1;
            exc_active <= 1'b1;
          end
        end
        ADDR: state <= WAIT;
        WAIT: begin
          state   <= LOAD;
          pc_next <= {24'h000000, mem_data_in[7:0]};
          pc_load <= 1'b1;
        end
        LOAD: begin
          state      <= IDLE;
          exc_active <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed, table-driven bench for exception_ctrl with a one-cycle-latency
// memory model holding the three handler vector bytes.
module tb_exception_ctrl;
  logic        clk = 1'b0;
  logic        reset_n;
  logic [2:0]  ctrl_iord_sel;
  logic        exc_opcode, exc_overflow, exc_div0;
  logic [31:0] pc_in;
  logic [31:0] mem_data_in;
  logic [2:0]  iord_sel;
  logic [31:0] epc_out;
  logic        epc_write;
  logic [31:0] pc_next;
  logic        pc_load;
  logic        exc_active;
  logic [1:0]  exc_cause;

  logic [7:0] m253, m254, m255;

  int checks   = 0;
  int failures = 0;

  exception_ctrl dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .ctrl_iord_sel (ctrl_iord_sel),
    .exc_opcode    (exc_opcode),
    .exc_overflow  (exc_overflow),
    .exc_div0      (exc_div0),
    .pc_in         (pc_in),
    .mem_data_in   (mem_data_in),
    .iord_sel      (iord_sel),
    .epc_out       (epc_out),
    .epc_write     (epc_write),
    .pc_next       (pc_next),
    .pc_load       (pc_load),
    .exc_active    (exc_active),
    .exc_cause     (exc_cause)
  );

  always #5 clk = ~clk;

  // Upper bits are junk so zero-extension of the handler byte is exercised.
  always @(posedge clk) begin
    case (iord_sel)
      3'b010:  mem_data_in <= {24'hDEADBE, m253};
      3'b011:  mem_data_in <= {24'hDEADBE, m254};
      3'b100:  mem_data_in <= {24'hDEADBE, m255};
      default: mem_data_in <= 32'hDEADBE11;
    endcase
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [2:0] ctrl;
    logic [2:0] exp_sel;
  } sel_vec_t;

  typedef struct {
    logic        op, ovf, dz;
    logic [31:0] pc;
    logic [7:0]  mbyte;
    logic [1:0]  cause;
    logic [2:0]  vec;
    logic [31:0] epc;
  } exc_vec_t;

  sel_vec_t sv[8];
  exc_vec_t ev[5];

  // Full IDLE->ADDR->WAIT->LOAD->IDLE run, starting and ending on a negedge.
  task automatic run_exc(input exc_vec_t r, input int idx);
    m253 = 8'h33; m254 = 8'h44; m255 = 8'h55;
    case (r.vec)
      3'b010:  m253 = r.mbyte;
      3'b011:  m254 = r.mbyte;
      default: m255 = r.mbyte;
    endcase
    ctrl_iord_sel = 3'b001;
    pc_in = r.pc;
    exc_opcode = r.op; exc_overflow = r.ovf; exc_div0 = r.dz;
    @(negedge clk);
    exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
    pc_in = 32'h0BAD0000;
    chk($sformatf("v%0d c1 epc_write", idx), 32'(epc_write), 32'd1);
    chk($sformatf("v%0d c1 exc_active", idx), 32'(exc_active), 32'd1);
    chk($sformatf("v%0d c1 pc_load", idx), 32'(pc_load), 32'd0);
    chk($sformatf("v%0d c1 iord_sel", idx), 32'(iord_sel), 32'(r.vec));
    chk($sformatf("v%0d c1 epc_out", idx), epc_out, r.epc);
    chk($sformatf("v%0d c1 exc_cause", idx), 32'(exc_cause), 32'(r.cause));
    @(negedge clk);
    chk($sformatf("v%0d c2 epc_write", idx), 32'(epc_write), 32'd0);
    chk($sformatf("v%0d c2 iord_sel", idx), 32'(iord_sel), 32'(r.vec));
    chk($sformatf("v%0d c2 pc_load", idx), 32'(pc_load), 32'd0);
    chk($sformatf("v%0d c2 exc_active", idx), 32'(exc_active), 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d c3 pc_load", idx), 32'(pc_load), 32'd1);
    chk($sformatf("v%0d c3 pc_next", idx), pc_next, {24'h0, r.mbyte});
    chk($sformatf("v%0d c3 iord_sel", idx), 32'(iord_sel), 32'd0);
    chk($sformatf("v%0d c3 exc_active", idx), 32'(exc_active), 32'd1);
    @(negedge clk);
    chk($sformatf("v%0d c4 exc_active", idx), 32'(exc_active), 32'd0);
    chk($sformatf("v%0d c4 pc_load", idx), 32'(pc_load), 32'd0);
    chk($sformatf("v%0d c4 iord_sel", idx), 32'(iord_sel), 32'd1);
    chk($sformatf("v%0d c4 exc_cause held", idx), 32'(exc_cause), 32'(r.cause));
    chk($sformatf("v%0d c4 epc_out held", idx), epc_out, r.epc);
  endtask

  int pl_count;

  initial begin
    sv[0] = '{3'b000, 3'b000}; sv[1] = '{3'b001, 3'b001};
    sv[2] = '{3'b010, 3'b000}; sv[3] = '{3'b011, 3'b000};
    sv[4] = '{3'b100, 3'b000}; sv[5] = '{3'b101, 3'b000};
    sv[6] = '{3'b110, 3'b000}; sv[7] = '{3'b111, 3'b000};

    ev[0] = '{1'b0, 1'b1, 1'b0, 32'h00000040, 8'h80, 2'b10, 3'b011, 32'h0000003C};
    ev[1] = '{1'b1, 1'b1, 1'b1, 32'h00000100, 8'h5A, 2'b01, 3'b010, 32'h000000FC};
    ev[2] = '{1'b1, 1'b0, 1'b0, 32'h00000000, 8'h21, 2'b01, 3'b010, 32'hFFFFFFFC};
    ev[3] = '{1'b0, 1'b0, 1'b1, 32'h00001234, 8'hFF, 2'b11, 3'b100, 32'h00001230};
    ev[4] = '{1'b0, 1'b1, 1'b1, 32'h80000000, 8'h07, 2'b10, 3'b011, 32'h7FFFFFFC};

    reset_n = 1'b0;
    ctrl_iord_sel = 3'b011;
    exc_opcode = 1'b0; exc_overflow = 1'b0; exc_div0 = 1'b0;
    pc_in = '0;
    m253 = 8'h33; m254 = 8'h44; m255 = 8'h55;
    #3;
    chk("rst exc_active", 32'(exc_active), 32'd0);
    chk("rst epc_out", epc_out, 32'd0);
    chk("rst pc_next", pc_next, 32'd0);
    chk("rst exc_cause", 32'(exc_cause), 32'd0);
    chk("rst epc_write", 32'(epc_write), 32'd0);
    chk("rst pc_load", 32'(pc_load), 32'd0);
    chk("rst iord_sel 011", 32'(iord_sel), 32'd0);
    ctrl_iord_sel = 3'b001;
    #1 chk("rst iord_sel 001", 32'(iord_sel), 32'd1);
    @(negedge clk);
    reset_n = 1'b1;

    for (int unsigned i = 0; i < 8; i++) begin
      @(negedge clk);
      ctrl_iord_sel = sv[i].ctrl;
      #1 chk($sformatf("sweep %0d iord_sel", i), 32'(iord_sel), 32'(sv[i].exp_sel));
    end
    @(negedge clk);

    for (int unsigned i = 0; i < 5; i++) run_exc(ev[i], int'(i));

    // div0 raised in WAIT of an opcode exception and held into IDLE.
    m253 = 8'h61; m255 = 8'h9C;
    ctrl_iord_sel = 3'b000; pc_in = 32'h00000400; exc_opcode = 1'b1;
    pl_count = 0;
    @(negedge clk);
    exc_opcode = 1'b0;
    pl_count += int'(pc_load);
    @(negedge clk);
    pl_count += int'(pc_load);
    exc_div0 = 1'b1;
    @(negedge clk);
    pl_count += int'(pc_load);
    chk("ign cause in LOAD", 32'(exc_cause), 32'd1);
    @(negedge clk);
    pl_count += int'(pc_load);
    chk("ign exc_active at idle", 32'(exc_active), 32'd0);
    chk("ign cause at idle", 32'(exc_cause), 32'd1);
    chk("ign pc_load count", 32'(pl_count), 32'd1);
    chk("ign epc kept", epc_out, 32'h000003FC);
    @(negedge clk);
    exc_div0 = 1'b0;
    chk("resume exc_active", 32'(exc_active), 32'd1);
    chk("resume cause", 32'(exc_cause), 32'd3);
    chk("resume epc_write", 32'(epc_write), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("resume pc_next", pc_next, 32'h0000009C);
    @(negedge clk);

    // Reset asserted in WAIT aborts the sequence.
    ctrl_iord_sel = 3'b001; pc_in = 32'h00000200; exc_overflow = 1'b1;
    @(negedge clk);
    exc_overflow = 1'b0;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("abort exc_active", 32'(exc_active), 32'd0);
    chk("abort epc_out", epc_out, 32'd0);
    chk("abort pc_next", pc_next, 32'd0);
    chk("abort exc_cause", 32'(exc_cause), 32'd0);
    chk("abort epc_write", 32'(epc_write), 32'd0);
    chk("abort iord_sel", 32'(iord_sel), 32'd1);
    @(negedge clk);
    chk("abort no pc_load", 32'(pc_load), 32'd0);
    ctrl_iord_sel = 3'b011;
    #1 chk("abort iord_sel 011", 32'(iord_sel), 32'd0);
    @(negedge clk);
    reset_n = 1'b1; exc_opcode = 1'b1; pc_in = 32'h00000010; m253 = 8'h42;
    @(negedge clk);
    exc_opcode = 1'b0;
    chk("post-rst exc_active", 32'(exc_active), 32'd1);
    chk("post-rst cause", 32'(exc_cause), 32'd1);
    chk("post-rst epc_out", epc_out, 32'h0000000C);
    @(negedge clk);
    @(negedge clk);
    chk("post-rst pc_load", 32'(pc_load), 32'd1);
    chk("post-rst pc_next", pc_next, 32'h00000042);
    @(negedge clk);
    chk("post-rst idle", 32'(exc_active), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exception_ctrl.md
EXCEPTION_CTRL -- requirements
Module: exception_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset: clk (rising edge) and reset_n (active-low, asynchronous assert).
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  system clock
- reset_n  in  1  async active-low reset
- ctrl_iord_sel  in  3  address select from main control
- exc_opcode  in  1  invalid-opcode flag
- exc_overflow  in  1  ALU overflow flag
- exc_div0  in  1  divide-by-zero flag
- pc_in  in  32  current (already incremented) PC
- mem_data_in  in  32  memory read data
- iord_sel  out  3  select to memory-address mux
- epc_out  out  32  saved exception PC
- epc_write  out  1  one-cycle EPC update strobe
- pc_next  out  32  handler address
- pc_load  out  1  one-cycle PC load strobe
- exc_active  out  1  stall request to main control
- exc_cause  out  2  last cause code

Function
REQ-003 The state machine SHALL have four states: IDLE, ADDR, WAIT and LOAD.
REQ-004 In IDLE, iord_sel SHALL equal ctrl_iord_sel when that value is 000 or 001, and SHALL be 000 for any other value.
REQ-005 In IDLE, any exception flag high at a rising edge SHALL move the state to ADDR and register the cause, epc_out and the vector select.
REQ-006 Simultaneous flags SHALL resolve by priority: opcode, then overflow, then div0.
REQ-007 Cause codes SHALL be: 00 none, 01 opcode, 10 overflow, 11 div0.
REQ-008 Vector selects SHALL be: opcode 010 (address 253), overflow 011 (254), div0 100 (255).
REQ-009 epc_out SHALL be pc_in minus 4, modulo 2^32; pc_in=0x00000000 yields 0xFFFFFFFC.
REQ-010 In ADDR, iord_sel SHALL be the registered vector select and epc_write SHALL be 1 for this single cycle.
REQ-011 In WAIT, iord_sel SHALL hold the vector select, and the block SHALL register mem_data_in[7:0] at the end of the cycle; memory read latency is one cycle.
REQ-012 In LOAD, pc_next SHALL be the registered byte zero-extended to 32 bits, pc_load SHALL be 1 for one cycle, iord_sel SHALL be 000, and the next state SHALL be IDLE.
REQ-013 exc_active SHALL be 1 in ADDR, WAIT and LOAD, and 0 in IDLE.
REQ-014 Latency: pc_load SHALL assert exactly 3 cycles after the detecting edge; the IDLE-to-IDLE sequence SHALL be 4 cycles.
REQ-015 Exception flags SHALL be ignored outside IDLE; no queuing and no cause overwrite.
REQ-016 A flag still high on the edge that enters IDLE from LOAD SHALL NOT be sampled; detection SHALL resume on the following edge.
REQ-017 exc_cause and epc_out SHALL hold their values until the next accepted exception.
REQ-018 pc_next SHALL hold its last value outside LOAD; its value is don't-care when pc_load is 0.

Reset
REQ-019 Reset assertion SHALL immediately force: state IDLE, epc_out 0, pc_next 0, exc_cause 00, epc_write 0, pc_load 0, and exc_active 0.
REQ-020 During reset, iord_sel SHALL follow REQ-004.
REQ-021 Reset mid-sequence (ADDR, WAIT or LOAD) SHALL abort the sequence with no pc_load pulse.
REQ-022 The first sampling edge after reset deassertion SHALL evaluate exception flags normally.

Structure
REQ-023 A shared package exc_pkg SHALL hold the state encoding, cause codes, vector select codes (010/011/100) and the EPC offset constant (4).
REQ-024 The fixed-priority cause encoder SHALL be the single sub-module, exc_priority_enc (3 flags in, valid plus 2-bit cause out).
REQ-025 All other logic SHALL be inline.

Verification
REQ-026 exc_overflow pulse with pc_in=0x00000040 in IDLE, memory byte at 254 = 0x80 -> epc_write in cycle 1 with epc_out=0x0000003C; iord_sel=011 in cycles 1-2; pc_load in cycle 3 with pc_next=0x00000080; exc_cause=10.
REQ-027 All three flags high together -> exc_cause=01, iord_sel=010.
REQ-028 exc_div0 raised during WAIT of an opcode exception -> ignored, exc_cause stays 01, only one pc_load pulse.
REQ-029 pc_in=0x00000000 with exc_opcode -> epc_out=0xFFFFFFFC.
REQ-030 reset_n low in WAIT -> outputs at reset values immediately, no pc_load pulse, exc_active=0.
REQ-031 In IDLE, ctrl_iord_sel sweeps 000-111 -> iord_sel = 000, 001, then 000 for all others.
